// File: rtl/aes_block_mover_pkg.sv
// Shared MMIO map, control encodings and sequencer state type for the AES block mover.
package aes_mmio_pkg;

    localparam logic [31:0] AES_BASE    = 32'h0004_0000;
    localparam logic [11:0] IN_OFFSET   = 12'h000;
    localparam logic [11:0] CTRL_OFFSET = 12'h300;
    localparam logic [11:0] OUT_OFFSET  = 12'h404;

    localparam logic [2:0] CTRL_ENC      = 3'b001;
    localparam logic [2:0] CTRL_DEC      = 3'b010;
    localparam int         CTRL_DONE_BIT = 2;

    localparam int BLOCK_WORDS = 9;

    typedef enum logic [3:0] {
        IDLE,
        LOAD_RD,
        LOAD_WAIT,
        LOAD_WR,
        KICK,
        GUARD,
        POLL_RD,
        POLL_WAIT,
        UNLOAD_RD,
        UNLOAD_WAIT,
        UNLOAD_WR,
        NEXT,
        DONE
    } state_t;

    function automatic logic [31:0] aes_reg_addr(input logic [11:0] offset, input logic [3:0] word_idx);
        return AES_BASE + {20'd0, offset} + {26'd0, word_idx, 2'b00};
    endfunction

endpackage

// File: rtl/aes_block_mover_if.sv
// Command, system-memory and coprocessor buses of the AES block mover.
interface aes_block_mover_if;

    logic        cmd_valid_in;
    logic        cmd_ready_out;
    logic [31:0] cmd_src_in;
    logic [31:0] cmd_dst_in;
    logic [15:0] cmd_blocks_in;
    logic        cmd_decrypt_in;

    logic [31:0] mem_addr_out;
    logic [3:0]  mem_we_out;
    logic [31:0] mem_data_out;
    logic [31:0] mem_data_in;

    logic [31:0] aes_addr_out;
    logic [3:0]  aes_we_out;
    logic [31:0] aes_data_out;
    logic [31:0] aes_data_in;

    logic        busy_out;
    logic        done_out;
    logic        err_out;

    modport master (
        input  cmd_valid_in, cmd_src_in, cmd_dst_in, cmd_blocks_in, cmd_decrypt_in,
        input  mem_data_in, aes_data_in,
        output cmd_ready_out, mem_addr_out, mem_we_out, mem_data_out,
        output aes_addr_out, aes_we_out, aes_data_out, busy_out, done_out, err_out
    );

    modport slave (
        output cmd_valid_in, cmd_src_in, cmd_dst_in, cmd_blocks_in, cmd_decrypt_in,
        output mem_data_in, aes_data_in,
        input  cmd_ready_out, mem_addr_out, mem_we_out, mem_data_out,
        input  aes_addr_out, aes_we_out, aes_data_out, busy_out, done_out, err_out
    );

endinterface

// File: rtl/aes_mover_lat_cnt.sv
// Loadable down-counter; load N-1 to wait N cycles, zero flags the last one.
module aes_mover_lat_cnt #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/aes_block_mover.sv
// Descriptor-driven mover: streams blocks memory -> AES input buffer, kicks and polls the
// coprocessor, then streams the output buffer back to memory.
module aes_block_mover
    import aes_mmio_pkg::*;
#(
    parameter int MEM_RD_LAT = 2,
    parameter int AES_RD_LAT = 2,
    parameter int TIMEOUT    = 4096
) (
    input  logic              clk_in,
    input  logic              rst_in,
    aes_block_mover_if.master bus
);

    localparam int          LAT_W     = 4;
    localparam int          TMO_W     = $clog2(TIMEOUT + 1);
    localparam logic [3:0]  LAST_WORD = 4'(BLOCK_WORDS - 1);
    localparam logic [31:0] CTRL_ADDR = AES_BASE + {20'd0, CTRL_OFFSET};

    state_t            state_q, next_state;
    logic [31:0]       src_q, dst_q, word_q;
    logic [31:0]       mem_addr_q, aes_addr_q;
    logic [15:0]       blocks_q;
    logic              dec_q, err_q;
    logic [3:0]        word_idx_q;
    logic [TMO_W-1:0]  tmo_q;

    logic              lat_load, lat_zero;
    logic [LAT_W-1:0]  lat_value;
    logic              accept, polling, poll_hit, timeout, last_word;

    logic [31:0]       mem_addr, aes_addr, aes_data;
    logic [3:0]        mem_we, aes_we;

    aes_mover_lat_cnt #(.WIDTH(LAT_W)) u_lat_cnt (
        .clk   (clk_in),
        .rst_n (rst_in),
        .load  (lat_load),
        .value (lat_value),
        .zero  (lat_zero)
    );

    assign last_word = (word_idx_q == LAST_WORD);
    assign polling   = (state_q == GUARD) || (state_q == POLL_RD) || (state_q == POLL_WAIT);
    assign poll_hit  = (state_q == POLL_WAIT) && lat_zero && bus.aes_data_in[CTRL_DONE_BIT];
    // Cycle count starts with KICK, so the limit trips on the TIMEOUT-th cycle after it.
    assign timeout   = polling && (tmo_q == TMO_W'(TIMEOUT - 1)) && !poll_hit;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= next_state;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state_q;
        accept     = 1'b0;
        lat_load   = 1'b0;
        lat_value  = '0;
        mem_addr   = mem_addr_q;
        mem_we     = 4'h0;
        aes_addr   = aes_addr_q;
        aes_we     = 4'h0;
        aes_data   = word_q;

        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid_in) begin
                    accept     = 1'b1;
                    next_state = (bus.cmd_blocks_in == 16'd0) ? DONE : LOAD_RD;
                end
            end
            LOAD_RD: begin
                mem_addr   = src_q;
                lat_load   = 1'b1;
                lat_value  = LAT_W'(MEM_RD_LAT - 1);
                next_state = LOAD_WAIT;
            end
            LOAD_WAIT: begin
                mem_addr = src_q;
                if (lat_zero) next_state = LOAD_WR;
            end
            LOAD_WR: begin
                aes_addr   = aes_reg_addr(IN_OFFSET, word_idx_q);
                aes_we     = 4'hf;
                next_state = last_word ? KICK : LOAD_RD;
            end
            KICK: begin
                aes_addr   = CTRL_ADDR;
                aes_we     = 4'hf;
                aes_data   = {29'd0, dec_q ? CTRL_DEC : CTRL_ENC};
                lat_load   = 1'b1;
                lat_value  = LAT_W'(1);
                next_state = GUARD;
            end
            GUARD: begin
                if (lat_zero) next_state = POLL_RD;
            end
            POLL_RD: begin
                aes_addr   = CTRL_ADDR;
                lat_load   = 1'b1;
                lat_value  = LAT_W'(AES_RD_LAT - 1);
                next_state = POLL_WAIT;
            end
            POLL_WAIT: begin
                aes_addr = CTRL_ADDR;
                if (lat_zero) next_state = poll_hit ? UNLOAD_RD : POLL_RD;
            end
            UNLOAD_RD: begin
                aes_addr   = aes_reg_addr(OUT_OFFSET, word_idx_q);
                lat_load   = 1'b1;
                lat_value  = LAT_W'(AES_RD_LAT - 1);
                next_state = UNLOAD_WAIT;
            end
            UNLOAD_WAIT: begin
                aes_addr = aes_reg_addr(OUT_OFFSET, word_idx_q);
                if (lat_zero) next_state = UNLOAD_WR;
            end
            UNLOAD_WR: begin
                mem_addr   = dst_q;
                mem_we     = 4'hf;
                next_state = last_word ? NEXT : UNLOAD_RD;
            end
            NEXT: begin
                next_state = (blocks_q == 16'd1) ? DONE : LOAD_RD;
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        if (timeout) next_state = DONE;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            src_q      <= '0;
            dst_q      <= '0;
            word_q     <= '0;
            mem_addr_q <= '0;
            aes_addr_q <= '0;
            blocks_q   <= '0;
            dec_q      <= 1'b0;
            err_q      <= 1'b0;
            word_idx_q <= '0;
            tmo_q      <= '0;
        end else begin
            mem_addr_q <= mem_addr;
            aes_addr_q <= aes_addr;

            if (accept) begin
                src_q      <= bus.cmd_src_in;
                dst_q      <= bus.cmd_dst_in;
                blocks_q   <= bus.cmd_blocks_in;
                dec_q      <= bus.cmd_decrypt_in;
                word_idx_q <= '0;
                err_q      <= 1'b0;
            end

            unique case (state_q)
                LOAD_WAIT: begin
                    if (lat_zero) word_q <= bus.mem_data_in;
                end
                LOAD_WR: begin
                    src_q      <= src_q + 32'd4;
                    word_idx_q <= last_word ? 4'd0 : word_idx_q + 4'd1;
                end
                KICK: begin
                    tmo_q <= TMO_W'(1);
                end
                GUARD, POLL_RD, POLL_WAIT: begin
                    tmo_q <= tmo_q + 1'b1;
                end
                UNLOAD_WAIT: begin
                    if (lat_zero) word_q <= bus.aes_data_in;
                end
                UNLOAD_WR: begin
                    dst_q      <= dst_q + 32'd4;
                    word_idx_q <= last_word ? 4'd0 : word_idx_q + 4'd1;
                end
                NEXT: begin
                    blocks_q <= blocks_q - 16'd1;
                end
                default: begin
                end
            endcase

            if (timeout) err_q <= 1'b1;
        end
    end

    assign bus.cmd_ready_out = (state_q == IDLE);
    assign bus.busy_out      = (state_q != IDLE);
    assign bus.done_out      = (state_q == DONE);
    assign bus.err_out       = err_q;
    assign bus.mem_addr_out  = mem_addr;
    assign bus.mem_we_out    = mem_we;
    assign bus.mem_data_out  = word_q;
    assign bus.aes_addr_out  = aes_addr;
    assign bus.aes_we_out    = aes_we;
    assign bus.aes_data_out  = aes_data;

endmodule

// File: tb/tb_aes_block_mover.sv
// Scoreboard bench: memory and coprocessor stubs, expected bus writes queued per command.
module tb_aes_block_mover;

    localparam logic [31:0] BASE      = 32'h0004_0000;
    localparam logic [31:0] CTRL_A    = 32'h0004_0300;
    localparam logic [31:0] OUT_A     = 32'h0004_0404;
    localparam int          WORDS     = 9;
    localparam int          TMO       = 64;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_block_mover_if bus ();

    aes_block_mover #(.MEM_RD_LAT(2), .AES_RD_LAT(2), .TIMEOUT(TMO)) dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .bus    (bus)
    );

    int checks = 0;
    int failures = 0;
    int ctrl_writes = 0;
    int aes_writes = 0;
    int mem_writes = 0;
    int done_seen = 0;
    bit prev_done = 1'b0;

    wr_t exp_aes[$];
    wr_t exp_mem[$];
    bit  exp_done[$];

    logic [31:0] sys_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return sys_mem.exists(a) ? sys_mem[a] : init_val(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    // Invertible stand-in for the cipher: rotate-left 7 plus a per-word key.
    function automatic logic [31:0] xform(input logic [31:0] x, input int w, input bit dec);
        logic [31:0] k, y;
        k = 32'hA5C3_0000 + 32'(w) * 32'h1111;
        if (!dec) return {x[24:0], x[31:25]} + k;
        y = x - k;
        return {y[6:0], y[31:7]};
    endfunction

    // ---------------- system memory stub ----------------
    logic [31:0] mem_p1 = '0;
    always @(posedge clk) begin
        mem_p1 <= bus.mem_addr_out;
        bus.mem_data_in <= mem_rd(mem_p1);
        if (bus.mem_we_out == 4'hf) sys_mem[bus.mem_addr_out] = bus.mem_data_out;
    end

    // ---------------- coprocessor stub ----------------
    logic [31:0] cp_in  [WORDS];
    logic [31:0] cp_out [WORDS];
    logic [2:0]  cp_mode = '0;
    logic        cp_done = 1'b0;
    int          cp_timer = 0;
    bit          coproc_hang = 1'b0;
    logic [31:0] aes_p1 = '0;

    function automatic logic [31:0] aes_rd(input logic [31:0] a);
        if (a == CTRL_A) return {29'd0, cp_done, cp_mode[1:0]};
        if (a >= OUT_A && (a - OUT_A) < 32'(4 * WORDS)) return cp_out[int'((a - OUT_A) >> 2)];
        return '0;
    endfunction

    always @(posedge clk) begin
        aes_p1 <= bus.aes_addr_out;
        bus.aes_data_in <= aes_rd(aes_p1);
        if (bus.aes_we_out == 4'hf) begin
            if (bus.aes_addr_out == CTRL_A) begin
                cp_mode <= bus.aes_data_out[2:0];
                cp_done <= 1'b0;
                if (coproc_hang) cp_timer <= 0;
                else cp_timer <= int'($urandom_range(3, 30));
            end else if ((bus.aes_addr_out - BASE) < 32'(4 * WORDS)) begin
                cp_in[int'((bus.aes_addr_out - BASE) >> 2)] <= bus.aes_data_out;
            end
        end else if (cp_timer > 0) begin
            if (cp_timer == 1) begin
                for (int w = 0; w < WORDS; w++) cp_out[w] <= xform(cp_in[w], w, cp_mode == 3'b010);
                cp_done <= 1'b1;
            end
            cp_timer <= cp_timer - 1;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        wr_t e;
        if (rst_n) begin
            if (bus.aes_we_out != 4'h0) begin
                aes_writes++;
                check("aes_we_full", 32'(bus.aes_we_out), 32'hf);
                check("bus_exclusive", 32'(bus.mem_we_out), 32'h0);
                check("aes_wr_expected", 32'(exp_aes.size() != 0), 32'd1);
                if (exp_aes.size() != 0) begin
                    e = exp_aes.pop_front();
                    check("aes_wr_addr", bus.aes_addr_out, e.addr);
                    check("aes_wr_data", bus.aes_data_out, e.data);
                end
                if (bus.aes_addr_out == CTRL_A) ctrl_writes++;
            end
            if (bus.mem_we_out != 4'h0) begin
                mem_writes++;
                check("mem_we_full", 32'(bus.mem_we_out), 32'hf);
                check("mem_wr_expected", 32'(exp_mem.size() != 0), 32'd1);
                if (exp_mem.size() != 0) begin
                    e = exp_mem.pop_front();
                    check("mem_wr_addr", bus.mem_addr_out, e.addr);
                    check("mem_wr_data", bus.mem_data_out, e.data);
                end
            end
            if (bus.done_out) begin
                done_seen++;
                check("done_single_cycle", 32'(prev_done), 32'd0);
                check("done_expected", 32'(exp_done.size() != 0), 32'd1);
                if (exp_done.size() != 0) check("done_err", 32'(bus.err_out), 32'(exp_done.pop_front()));
            end
        end
        prev_done = rst_n && bus.done_out;
    end

    // ---------------- reference model ----------------
    task automatic push_cmd(input logic [31:0] src, input logic [31:0] dst, input int n,
                            input bit dec, input bit hang);
        logic [31:0] blk [WORDS];
        logic [31:0] a, y;
        for (int b = 0; b < n; b++) begin
            for (int w = 0; w < WORDS; w++) begin
                a = src + 32'(36 * b) + 32'(4 * w);
                blk[w] = ref_rd(a);
                exp_aes.push_back('{addr: BASE + 32'(4 * w), data: blk[w]});
            end
            exp_aes.push_back('{addr: CTRL_A, data: dec ? 32'd2 : 32'd1});
            if (hang) begin
                exp_done.push_back(1'b1);
                return;
            end
            for (int w = 0; w < WORDS; w++) begin
                y = xform(blk[w], w, dec);
                a = dst + 32'(36 * b) + 32'(4 * w);
                exp_mem.push_back('{addr: a, data: y});
                ref_mem[a] = y;
            end
        end
        exp_done.push_back(1'b0);
    endtask

    task automatic put(input logic [31:0] a, input logic [31:0] d);
        sys_mem[a] = d;
        ref_mem[a] = d;
    endtask

    task automatic issue(input logic [31:0] src, input logic [31:0] dst, input int n,
                         input bit dec, input bit hang);
        int k = 0;
        while (!bus.cmd_ready_out && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("cmd_ready_before_issue", 32'(bus.cmd_ready_out), 32'd1);
        push_cmd(src, dst, n, dec, hang);
        bus.cmd_src_in     = src;
        bus.cmd_dst_in     = dst;
        bus.cmd_blocks_in  = 16'(n);
        bus.cmd_decrypt_in = dec;
        bus.cmd_valid_in   = 1'b1;
        @(negedge clk);
        bus.cmd_valid_in   = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((exp_done.size() != 0 || bus.busy_out) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("cmd_complete", 32'(exp_done.size() == 0 && !bus.busy_out), 32'd1);
    endtask

    logic [31:0] orig [WORDS];
    int c0, m0, d0, a0, k;

    initial begin
        orig = '{32'h6b2ee973, 32'hc1403d93, 32'h9e7a2c11, 32'h0f1e2d3c, 32'h4b5a6978,
                 32'h8796a5b4, 32'hc3d2e1f0, 32'h13579bdf, 32'hdeadbeef};
        bus.cmd_valid_in = 1'b0;
        bus.cmd_src_in = '0;
        bus.cmd_dst_in = '0;
        bus.cmd_blocks_in = '0;
        bus.cmd_decrypt_in = 1'b0;
        bus.mem_data_in = '0;
        bus.aes_data_in = '0;

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.cmd_ready_out), 32'd1);
        check("rst_busy", 32'(bus.busy_out), 32'd0);
        check("rst_done", 32'(bus.done_out), 32'd0);
        check("rst_err", 32'(bus.err_out), 32'd0);
        check("rst_we", {24'd0, bus.aes_we_out, bus.mem_we_out}, 32'd0);
        check("rst_addr", bus.aes_addr_out | bus.mem_addr_out, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // encrypt one block, then decrypt it back
        for (int w = 0; w < WORDS; w++) put(32'h100 + 32'(4 * w), orig[w]);
        d0 = done_seen;
        issue(32'h100, 32'h200, 1, 1'b0, 1'b0);
        wait_idle(2000);
        for (int w = 0; w < WORDS; w++)
            check("enc_result", sys_mem[32'h200 + 32'(4 * w)], xform(orig[w], w, 1'b0));
        check("enc_done_count", 32'(done_seen - d0), 32'd1);
        check("enc_err", 32'(bus.err_out), 32'd0);
        issue(32'h200, 32'h300, 1, 1'b1, 1'b0);
        wait_idle(2000);
        for (int w = 0; w < WORDS; w++)
            check("round_trip", sys_mem[32'h300 + 32'(4 * w)], orig[w]);

        // three contiguous blocks
        c0 = ctrl_writes; m0 = mem_writes; d0 = done_seen;
        issue(32'h1000, 32'h2000, 3, 1'b0, 1'b0);
        wait_idle(3000);
        check("multi_kicks", 32'(ctrl_writes - c0), 32'd3);
        check("multi_mem_writes", 32'(mem_writes - m0), 32'd27);
        check("multi_done_count", 32'(done_seen - d0), 32'd1);

        // zero blocks: prompt done, no bus writes
        a0 = aes_writes; m0 = mem_writes; d0 = done_seen;
        issue(32'h3000, 32'h3100, 0, 1'b0, 1'b0);
        @(negedge clk);
        check("zero_done_latency", 32'(done_seen - d0), 32'd1);
        check("zero_writes", 32'((aes_writes - a0) + (mem_writes - m0)), 32'd0);
        check("zero_idle", 32'(bus.busy_out), 32'd0);

        // address wrap past the top of the space
        issue(32'hFFFF_FFF0, 32'hFFFF_FFE0, 1, 1'b0, 1'b0);
        wait_idle(2000);

        // randomized descriptors
        for (int i = 0; i < 6; i++) begin
            issue(32'h8000 + 32'($urandom_range(0, 255)) * 32'd4,
                  32'hC000 + 32'($urandom_range(0, 255)) * 32'd4,
                  int'($urandom_range(1, 2)), 1'($urandom_range(0, 1)), 1'b0);
            wait_idle(3000);
        end

        // timeout: coprocessor never finishes
        coproc_hang = 1'b1;
        m0 = mem_writes;
        issue(32'h100, 32'h400, 2, 1'b0, 1'b1);
        wait_idle(1000);
        check("timeout_err_sticky", 32'(bus.err_out), 32'd1);
        check("timeout_no_mem", 32'(mem_writes - m0), 32'd0);
        coproc_hang = 1'b0;
        issue(32'h0, 32'h0, 0, 1'b0, 1'b0);
        check("err_cleared_on_accept", 32'(bus.err_out), 32'd0);
        wait_idle(100);

        // reset while polling, with a descriptor held during busy
        coproc_hang = 1'b1;
        c0 = ctrl_writes;
        issue(32'h4000, 32'h5000, 2, 1'b0, 1'b1);
        k = 0;
        while (ctrl_writes == c0 && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("reached_kick", 32'(ctrl_writes - c0), 32'd1);
        repeat (6) @(negedge clk);
        bus.cmd_src_in = 32'h6000;
        bus.cmd_dst_in = 32'h7000;
        bus.cmd_blocks_in = 16'd1;
        bus.cmd_valid_in = 1'b1;
        repeat (3) @(negedge clk);
        check("busy_not_ready", 32'(bus.cmd_ready_out), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_ready", 32'(bus.cmd_ready_out), 32'd1);
        check("abort_busy", 32'(bus.busy_out), 32'd0);
        check("abort_done", 32'(bus.done_out), 32'd0);
        check("abort_we", {24'd0, bus.aes_we_out, bus.mem_we_out}, 32'd0);
        check("abort_aes_pending", 32'(exp_aes.size()), 32'd0);
        exp_mem.delete();
        exp_done.delete();
        bus.cmd_valid_in = 1'b0;
        coproc_hang = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        a0 = aes_writes; m0 = mem_writes; d0 = done_seen;
        repeat (20) @(negedge clk);
        check("post_reset_ready", 32'(bus.cmd_ready_out), 32'd1);
        check("busy_cmd_dropped", 32'((aes_writes - a0) + (mem_writes - m0) + (done_seen - d0)), 32'd0);

        check("scoreboard_drained", 32'(exp_aes.size() + exp_mem.size() + exp_done.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
